// File: rtl/mp8_control_fsm.sv
// Fetch/decode/execute sequencer for the MP8 core: owns PC/IR, runs the req/ack memory port, issues strobes.
// Build option: MP8_SINGLE_STEP_EN adds a step input that gates each instruction fetch.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_FETCH  | read opcode @pc into ir
// S_DECODE | one cycle for the external decoder to settle on ir
// S_OPR1   | read second byte @pc into imm
// S_OPR2   | read third byte @pc into op_hi
// S_EXEC   | resolve branch / issue strobes / launch load-store
// S_MEM    | load or store @{op_hi,imm}
// S_HALT   | parked until reset, no memory traffic
module mp8_control_fsm #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MP8_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        ir,
  input  logic [1:0]        dec_inst_length,
  input  logic              dec_memr,
  input  logic              dec_memw,
  input  logic              dec_reg_write,
  input  logic              dec_alu_enable,
  input  logic              dec_halt,
  input  logic              dec_is_branch,
  input  logic [3:0]        dec_branch_type,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic              flag_s,
  input  logic              flag_p,
  input  logic [7:0]        acc_in,
  output logic [7:0]        imm,
  output logic [7:0]        ld_data,
  output logic              rf_we,
  output logic              alu_go,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_done,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPR1, S_OPR2, S_EXEC, S_MEM, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [7:0]          imm_q, imm_d;
  logic [7:0]          op_hi_q, op_hi_d;
  logic [7:0]          ld_data_q, ld_data_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic                ld_wb_q, ld_wb_d;

  logic                ack_fire;
  logic                step_ok;
  logic                taken;
  logic                exec_rf_we;
  logic [ADDR_W-1:0]   target_addr;

  function automatic logic is_req_state(input state_t s);
    return (s == S_FETCH) || (s == S_OPR1) || (s == S_OPR2) || (s == S_MEM);
  endfunction

`ifdef MP8_SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign ack_fire    = req_q & mem_ack;
  assign target_addr = ADDR_W'({op_hi_q, imm_q});

  always_comb begin
    taken = 1'b0;
    case (dec_branch_type)
      4'd0:    taken = 1'b1;
      4'd1:    taken = flag_z;
      4'd2:    taken = ~flag_z;
      4'd3:    taken = flag_c;
      4'd4:    taken = ~flag_c;
      4'd5:    taken = ~flag_s;
      4'd6:    taken = flag_s;
      4'd7:    taken = flag_p;
      4'd8:    taken = ~flag_p;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    imm_d      = imm_q;
    op_hi_d    = op_hi_q;
    ld_data_d  = ld_data_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    ld_wb_d    = 1'b0;
    exec_rf_we = 1'b0;
    alu_go     = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (ack_fire) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_halt)                state_d = S_HALT;
        else if (dec_inst_length[1]) state_d = S_OPR1;
        else                         state_d = S_EXEC;
      end
      S_OPR1: begin
        if (ack_fire) begin
          imm_d   = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = (dec_inst_length == 2'd3) ? S_OPR2 : S_EXEC;
        end
      end
      S_OPR2: begin
        if (ack_fire) begin
          op_hi_d = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec_is_branch) begin
          if (taken) pc_d = target_addr;
          state_d    = S_FETCH;
          instr_done = 1'b1;
        end else if (dec_memr | dec_memw) begin
          we_d    = dec_memw;
          wdata_d = acc_in;
          state_d = S_MEM;
        end else begin
          exec_rf_we = dec_reg_write;
          alu_go     = dec_alu_enable;
          state_d    = S_FETCH;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        if (ack_fire) begin
          if (!we_q) begin
            ld_data_d = mem_rdata;
            ld_wb_d   = 1'b1;
          end
          we_d       = 1'b0;
          state_d    = S_FETCH;
          instr_done = 1'b1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // A request drops for at least one cycle after every accepted ack.
    req_d = 1'b0;
    if (is_req_state(state_d)) begin
      if (state_d != state_q)
        req_d = ~ack_fire & ((state_d != S_FETCH) | step_ok);
      else
        req_d = req_q | (state_d != S_FETCH) | step_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      imm_q     <= 8'h00;
      op_hi_q   <= 8'h00;
      ld_data_q <= 8'h00;
      wdata_q   <= 8'h00;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      ld_wb_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      op_hi_q   <= op_hi_d;
      ld_data_q <= ld_data_d;
      wdata_q   <= wdata_d;
      req_q     <= req_d;
      we_q      <= we_d;
      ld_wb_q   <= ld_wb_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = (state_q == S_MEM) ? target_addr : pc_q;
  assign mem_wdata = wdata_q;
  assign ir        = ir_q;
  assign imm       = imm_q;
  assign ld_data   = ld_data_q;
  assign pc        = pc_q;
  assign rf_we     = exec_rf_we | ld_wb_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_mp8_control_fsm.sv
// Self-checking bench for mp8_control_fsm: table of single-instruction vectors plus hand-written
// sequences for wait-stated store, halt, PC wrap and reset during a load.
module tb_mp8_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b1;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic [7:0]  ir;
  logic [1:0]  dec_inst_length;
  logic        dec_memr, dec_memw, dec_reg_write, dec_alu_enable, dec_halt, dec_is_branch;
  logic [3:0]  dec_branch_type;
  logic        flag_z = 1'b0, flag_c = 1'b0, flag_s = 1'b0, flag_p = 1'b0;
  logic [7:0]  acc_in = 8'h00;
  logic [7:0]  imm, ld_data;
  logic        rf_we, alu_go, instr_done, halted;
  logic [15:0] pc;

  mp8_control_fsm #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MP8_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir(ir),
    .dec_inst_length(dec_inst_length), .dec_memr(dec_memr), .dec_memw(dec_memw),
    .dec_reg_write(dec_reg_write), .dec_alu_enable(dec_alu_enable), .dec_halt(dec_halt),
    .dec_is_branch(dec_is_branch), .dec_branch_type(dec_branch_type),
    .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s), .flag_p(flag_p),
    .acc_in(acc_in), .imm(imm), .ld_data(ld_data), .rf_we(rf_we), .alu_go(alu_go),
    .pc(pc), .instr_done(instr_done), .halted(halted)
  );

  always #5 clk = ~clk;

  // Minimal instruction decoder for the opcodes the bench uses.
  always_comb begin
    dec_inst_length = 2'd1;
    dec_memr = 1'b0; dec_memw = 1'b0; dec_reg_write = 1'b0; dec_alu_enable = 1'b0;
    dec_halt = 1'b0; dec_is_branch = 1'b0; dec_branch_type = 4'd0;
    case (ir)
      8'h3E: begin dec_inst_length = 2'd2; dec_reg_write = 1'b1; end
      8'h80: begin dec_reg_write = 1'b1; dec_alu_enable = 1'b1; end
      8'h3A: begin dec_inst_length = 2'd3; dec_memr = 1'b1; dec_reg_write = 1'b1; end
      8'h32: begin dec_inst_length = 2'd3; dec_memw = 1'b1; end
      8'h76: dec_halt = 1'b1;
      8'hC3: begin dec_inst_length = 2'd3; dec_is_branch = 1'b1; dec_branch_type = 4'd0; end
      8'hCA: begin dec_inst_length = 2'd3; dec_is_branch = 1'b1; dec_branch_type = 4'd1; end
      8'hC2: begin dec_inst_length = 2'd3; dec_is_branch = 1'b1; dec_branch_type = 4'd2; end
      8'hDA: begin dec_inst_length = 2'd3; dec_is_branch = 1'b1; dec_branch_type = 4'd3; end
      8'hD2: begin dec_inst_length = 2'd3; dec_is_branch = 1'b1; dec_branch_type = 4'd4; end
      8'hF2: begin dec_inst_length = 2'd3; dec_is_branch = 1'b1; dec_branch_type = 4'd5; end
      8'hFA: begin dec_inst_length = 2'd3; dec_is_branch = 1'b1; dec_branch_type = 4'd6; end
      8'hEA: begin dec_inst_length = 2'd3; dec_is_branch = 1'b1; dec_branch_type = 4'd7; end
      8'hE2: begin dec_inst_length = 2'd3; dec_is_branch = 1'b1; dec_branch_type = 4'd8; end
      8'hF0: begin dec_inst_length = 2'd3; dec_is_branch = 1'b1; dec_branch_type = 4'd9; end
      default: ;
    endcase
  end

  // Memory responder: acks wait_cycles cycles after it first sees mem_req.
  logic [7:0]  mem [0:65535];
  int          wait_cycles = 0;
  logic        resp_en = 1'b1;
  logic        inject_ack = 1'b0;
  int          wcnt = 0;
  int          wr_cnt = 0;
  logic [15:0] wr_addr = 16'h0;
  logic [7:0]  wr_data = 8'h0;

  always @(posedge clk) begin
    #1;
    if (inject_ack) begin
      mem_ack = 1'b1; mem_rdata = 8'hEE; wcnt = 0;
    end else if (!resp_en) begin
      mem_ack = 1'b0; wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (wcnt >= wait_cycles) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) begin
          wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata;
        end
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  int rf_cnt = 0, alu_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    rf_cnt   += int'(rf_we);
    alu_cnt  += int'(alu_go);
    done_cnt += int'(instr_done);
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out, event never seen", name);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input int base, input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (done_cnt != base) begin ok = 1; break; end
    end
    if (!ok) tmo(name);
  endtask

  task automatic wait_req(input string name, input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (mem_req) begin ok = 1; break; end
    end
    if (!ok) tmo(name);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [3:0]  f;      // {z,c,s,p}
    logic [7:0]  acc;
    logic [15:0] nxt;
    logic [7:0]  imm;
    int          rf;
    int          alu;
    logic [7:0]  ld;
    int          wr;
    logic [15:0] wa;
    logic [7:0]  wd;
  } vec_t;

  vec_t vecs [15];

  task automatic run_vec(input int idx, input vec_t v);
    int r0, a0, d0, w0;
    mem[16'h0000] = v.b0; mem[16'h0001] = v.b1; mem[16'h0002] = v.b2;
    mem[16'h2010] = 8'h77;
    {flag_z, flag_c, flag_s, flag_p} = v.f;
    acc_in = v.acc;
    wait_cycles = 0;
    apply_reset();
    r0 = rf_cnt; a0 = alu_cnt; d0 = done_cnt; w0 = wr_cnt;
    wait_done($sformatf("v%0d_done", idx), d0, 100);
    wait_req($sformatf("v%0d_refetch", idx), 20);
    check($sformatf("v%0d_next_addr", idx), mem_addr, v.nxt);
    check($sformatf("v%0d_pc", idx), pc, v.nxt);
    check($sformatf("v%0d_imm", idx), imm, v.imm);
    check($sformatf("v%0d_ld_data", idx), ld_data, v.ld);
    check($sformatf("v%0d_rf_we_pulses", idx), rf_cnt - r0, v.rf);
    check($sformatf("v%0d_alu_go_pulses", idx), alu_cnt - a0, v.alu);
    check($sformatf("v%0d_instr_done", idx), done_cnt - d0, 1);
    check($sformatf("v%0d_writes", idx), wr_cnt - w0, v.wr);
    if (v.wr != 0) begin
      check($sformatf("v%0d_wr_addr", idx), wr_addr, v.wa);
      check($sformatf("v%0d_wr_data", idx), wr_data, v.wd);
    end
  endtask

  initial begin
    int d0, r0, cnt, good;
    bit ok;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    //            b0     b1     b2     zcsp     acc    next      imm  rf alu ld    wr wa        wd
    vecs[0]  = '{8'h3E, 8'h5A, 8'h00, 4'b0000, 8'h00, 16'h0002, 8'h5A, 1, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[1]  = '{8'h80, 8'h00, 8'h00, 4'b0000, 8'h00, 16'h0001, 8'h00, 1, 1, 8'h00, 0, 16'h0000, 8'h00};
    vecs[2]  = '{8'hCA, 8'h34, 8'h12, 4'b1000, 8'h00, 16'h1234, 8'h34, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[3]  = '{8'hCA, 8'h34, 8'h12, 4'b0000, 8'h00, 16'h0003, 8'h34, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[4]  = '{8'hC3, 8'h00, 8'h40, 4'b0000, 8'h00, 16'h4000, 8'h00, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[5]  = '{8'hC2, 8'h34, 8'h12, 4'b0000, 8'h00, 16'h1234, 8'h34, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[6]  = '{8'hDA, 8'h10, 8'h00, 4'b0100, 8'h00, 16'h0010, 8'h10, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[7]  = '{8'hD2, 8'h10, 8'h00, 4'b0100, 8'h00, 16'h0003, 8'h10, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[8]  = '{8'hF2, 8'h10, 8'h00, 4'b0000, 8'h00, 16'h0010, 8'h10, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[9]  = '{8'hFA, 8'h10, 8'h00, 4'b0010, 8'h00, 16'h0010, 8'h10, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[10] = '{8'hEA, 8'h10, 8'h00, 4'b0000, 8'h00, 16'h0003, 8'h10, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[11] = '{8'hE2, 8'h10, 8'h00, 4'b0000, 8'h00, 16'h0010, 8'h10, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[12] = '{8'hF0, 8'h10, 8'h00, 4'b1111, 8'h00, 16'h0003, 8'h10, 0, 0, 8'h00, 0, 16'h0000, 8'h00};
    vecs[13] = '{8'h3A, 8'h10, 8'h20, 4'b0000, 8'h00, 16'h0003, 8'h10, 1, 0, 8'h77, 0, 16'h0000, 8'h00};
    vecs[14] = '{8'h32, 8'h00, 8'h80, 4'b0000, 8'hA5, 16'h0003, 8'h00, 0, 0, 8'h00, 1, 16'h8000, 8'hA5};

    // Reset state, then first cycle after release.
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_ir", ir, 8'h00);
    check("rst_halted", halted, 0);
    check("rst_rf_we", rf_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rel_mem_req", mem_req, 1);
    check("rel_mem_we", mem_we, 0);
    check("rel_mem_addr", mem_addr, 16'h0000);
    check("rel_pc", pc, 16'h0000);
    check("rel_halted", halted, 0);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // STA 8000 with three wait states; acc_in changes mid-transaction and must not leak.
    mem[16'h0000] = 8'h32; mem[16'h0001] = 8'h00; mem[16'h0002] = 8'h80;
    acc_in = 8'hA5; wait_cycles = 3;
    apply_reset();
    d0 = done_cnt; cnt = 0; good = 0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (mem_req && mem_we) begin
        cnt++;
        if (mem_addr == 16'h8000 && mem_wdata == 8'hA5) good++;
        acc_in = 8'h00;
      end
      if (done_cnt != d0) begin ok = 1; break; end
    end
    if (!ok) tmo("sta_wait_done");
    check("sta_we_cycles", cnt, 4);
    check("sta_stable_cycles", good, 4);
    check("sta_wr_data", wr_data, 8'hA5);
    @(negedge clk); #1;
    check("sta_req_low_after_ack", mem_req, 0);
    wait_cycles = 0;

    // HLT: parked with no traffic; a stray ack is ignored; reset restarts at 0000.
    mem[16'h0000] = 8'h76;
    apply_reset();
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (halted) begin ok = 1; break; end
    end
    if (!ok) tmo("hlt_enter");
    d0 = done_cnt; cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (mem_req || !halted) cnt++;
    end
    check("hlt_quiet_100", cnt, 0);
    resp_en = 1'b0; inject_ack = 1'b1;
    @(negedge clk); #1;
    inject_ack = 1'b0;
    @(negedge clk); #1;
    resp_en = 1'b1;
    check("hlt_stray_ack_ir", ir, 8'h76);
    check("hlt_stray_ack_halted", halted, 1);
    check("hlt_no_done", done_cnt - d0, 0);
    check("hlt_pc", pc, 16'h0001);
    rst_n = 1'b0; #1;
    check("hlt_rst_pc", pc, 16'h0000);
    check("hlt_rst_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("hlt_restart_req", mem_req, 1);
    check("hlt_restart_addr", mem_addr, 16'h0000);

    // JMP FFFF then MVI whose operand fetch wraps to 0000.
    mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'hFF; mem[16'h0002] = 8'hFF; mem[16'hFFFF] = 8'h3E;
    apply_reset();
    d0 = done_cnt;
    wait_done("wrap_jmp_done", d0, 100);
    @(negedge clk); #1;
    check("wrap_jmp_pc", pc, 16'hFFFF);
    r0 = rf_cnt;
    d0 = done_cnt;
    wait_done("wrap_mvi_done", d0, 100);
    check("wrap_pc", pc, 16'h0001);
    check("wrap_imm", imm, 8'hC3);
    check("wrap_rf_we", rf_cnt - r0, 1);

    // Reset asserted during the load phase of LDA 2010.
    mem[16'h0000] = 8'h3A; mem[16'h0001] = 8'h10; mem[16'h0002] = 8'h20; mem[16'h2010] = 8'h77;
    wait_cycles = 10;
    apply_reset();
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (mem_req && mem_addr == 16'h2010) begin ok = 1; break; end
    end
    if (!ok) tmo("lda_reach_mem");
    resp_en = 1'b0;
    r0 = rf_cnt;
    rst_n = 1'b0; #1;
    check("lda_rst_req_drop", mem_req, 0);
    check("lda_rst_we", mem_we, 0);
    inject_ack = 1'b1;
    @(negedge clk); #1;
    inject_ack = 1'b0;
    @(negedge clk); #1;
    check("lda_rst_no_rf_we", rf_cnt - r0, 0);
    check("lda_rst_ld_data", ld_data, 8'h00);
    check("lda_rst_ir", ir, 8'h00);
    check("lda_rst_pc", pc, 16'h0000);
    resp_en = 1'b1; wait_cycles = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("lda_restart_req", mem_req, 1);
    check("lda_restart_addr", mem_addr, 16'h0000);
    check("lda_restart_no_rf_we", rf_cnt - r0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
